// File: rtl/reg_pkg.sv
// Shared definitions for the reg_n storage register family.
//   REG_W_DEFAULT : default data width used when no width is given
//   REG_W_MAX     : widest register the family supports
//   reset_mask()  : trims a reset value to the register width so each flop
//                   can pick its own async clear/preset value
package reg_pkg;

  localparam int REG_W_DEFAULT = 8;
  localparam int REG_W_MAX     = 64;

  // Bits above w are forced to 0. Out-of-range widths are caught by the
  // elaboration check in reg_n, so this only needs to be well defined.
  function automatic logic [REG_W_MAX-1:0] reset_mask(input logic [REG_W_MAX-1:0] val,
                                                      input int                   w);
    logic [REG_W_MAX-1:0] mask;
    mask = '0;
    for (int i = 0; i < REG_W_MAX; i++) begin
      if (i < w) mask[i] = 1'b1;
    end
    return val & mask;
  endfunction

endpackage

// File: rtl/reg_n_bit.sv
// One enabled D flop with asynchronous, active-high reset.
//   clk_i : clock, captures on rising edge
//   rst_i : async reset, forces q_o to RST_BIT
//   en_i  : load enable; anything other than a clean 1 holds the flop
//   d_i   : data in
//   q_o   : registered data out (straight from the flop)
module reg_n_bit
  import reg_pkg::*;
#(
  parameter logic RST_BIT = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  input  logic d_i,
  output logic q_o
);

  logic q_q;
  logic q_d;

  // An unknown enable falls through to hold in simulation.
  always_comb begin
    q_d = q_q;
    if (en_i) q_d = d_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) q_q <= RST_BIT;
    else       q_q <= q_d;
  end

  assign q_o = q_q;

endmodule

// File: rtl/reg_n.sv
// Parameterised n-bit storage register with load enable and async clear.
//   clk  : single clock, all updates on its rising edge
//   rest : async active-high reset, forces q to RESET_VAL at once
//   en   : load enable, sampled at rising clk
//   D    : n-bit parallel data in
//   q    : n-bit registered data out, no combinational path from D/en
// Built as n independent reg_n_bit flops so each bit gets its own
// clear or preset according to RESET_VAL.
module reg_n
  import reg_pkg::*;
#(
  parameter int           n         = REG_W_DEFAULT,
  parameter logic [n-1:0] RESET_VAL = '0
) (
  input  logic         clk,
  input  logic         rest,
  input  logic         en,
  input  logic [n-1:0] D,
  output logic [n-1:0] q
);

  generate
    if (n < 1 || n > REG_W_MAX) begin : g_bad_n
      $fatal(1, "reg_n: width n=%0d outside 1..%0d", n, REG_W_MAX);
    end
  endgenerate

  // Full-width copy of the reset value, indexed per bit below.
  localparam logic [REG_W_MAX-1:0] RST_FULL = reset_mask(REG_W_MAX'(RESET_VAL), n);

  genvar gi;
  generate
    for (gi = 0; gi < n; gi++) begin : g_bit
      reg_n_bit #(
        .RST_BIT (RST_FULL[gi])
      ) u_bit (
        .clk_i (clk),
        .rst_i (rest),
        .en_i  (en),
        .d_i   (D[gi]),
        .q_o   (q[gi])
      );
    end
  endgenerate

`ifndef SYNTHESIS
  // Reset holds q at its reset value.
  a_rst_val : assert property (@(posedge clk) rest |-> q == RESET_VAL);

  // Enabled edge: the captured data shows up one edge later, unless a reset
  // intervened.
  a_load : assert property (@(posedge clk) disable iff (rest)
                            (!rest && en === 1'b1) |=> q == $past(D));

  // Disabled edge: q does not move.
  a_hold : assert property (@(posedge clk) disable iff (rest)
                            (!rest && en === 1'b0) |=> $stable(q));

  // Enable must be a clean level whenever it matters.
  a_en_known : assert property (@(posedge clk) !rest |-> !$isunknown(en));
`endif

endmodule

// File: tb/tb_reg_n.sv
module tb_reg_n;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [7:0] RV_ALT = 8'h5A;

  logic        rest, en, en_w;
  logic [7:0]  d8, q8, q8r;
  logic [0:0]  d1, q1;
  logic [31:0] d32, q32;

  reg_n #(.n(8)) u8 (.clk(clk), .rest(rest), .en(en), .D(d8), .q(q8));
  reg_n #(.n(8), .RESET_VAL(RV_ALT)) u8r (.clk(clk), .rest(rest), .en(en), .D(d8), .q(q8r));
  reg_n #(.n(1)) u1 (.clk(clk), .rest(rest), .en(en_w), .D(d1), .q(q1));
  reg_n #(.n(32)) u32 (.clk(clk), .rest(rest), .en(en_w), .D(d32), .q(q32));

  int checks = 0;
  int errors = 0;

  // Reference model: stored value of each register.
  logic [7:0]  m8, m8r;
  logic [0:0]  m1;
  logic [31:0] m32;

  typedef struct {
    logic       rest;
    logic       en;
    logic [7:0] d;
    logic [7:0] exp;
  } vec_t;

  vec_t tbl[9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Advance one rising edge, apply the register rules to the model, then
  // settle before any sampling.
  task automatic step();
    @(posedge clk);
    if (rest) begin
      m8 = 8'h00; m8r = RV_ALT; m1 = 1'b0; m32 = '0;
    end else begin
      if (en)   begin m8 = d8; m8r = d8; end
      if (en_w) begin m1 = d1; m32 = d32; end
    end
    #1;
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_q8"},  64'(q8),  64'(m8));
    chk({tag, "_q8r"}, 64'(q8r), 64'(m8r));
    chk({tag, "_q1"},  64'(q1),  64'(m1));
    chk({tag, "_q32"}, 64'(q32), 64'(m32));
  endtask

  initial begin
    rest = 1'b1; en = 1'b0; en_w = 1'b0;
    d8 = 8'h01; d1 = 1'b0; d32 = '0;
    m8 = 8'h00; m8r = RV_ALT; m1 = 1'b0; m32 = '0;

    tbl[0] = '{1'b1, 1'b0, 8'h01, 8'h00};
    tbl[1] = '{1'b1, 1'b1, 8'h33, 8'h00};
    tbl[2] = '{1'b1, 1'b1, 8'hFF, 8'h00};
    tbl[3] = '{1'b0, 1'b1, 8'h02, 8'h02};
    tbl[4] = '{1'b0, 1'b1, 8'hA5, 8'hA5};
    tbl[5] = '{1'b0, 1'b0, 8'h04, 8'hA5};
    tbl[6] = '{1'b0, 1'b0, 8'h04, 8'hA5};
    tbl[7] = '{1'b0, 1'b0, 8'h04, 8'hA5};
    tbl[8] = '{1'b0, 1'b1, 8'h08, 8'h08};

    // Power-up: reset value present before any clock edge.
    #1;
    chk("pwrup_q8",  64'(q8),  64'h00);
    chk("pwrup_q8r", 64'(q8r), 64'(RV_ALT));
    chk("pwrup_q1",  64'(q1),  64'h0);
    chk("pwrup_q32", 64'(q32), 64'h0);

    // Directed vectors: reset hold, load, hold, reload.
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      rest = tbl[i].rest; en = tbl[i].en; d8 = tbl[i].d;
      step();
      chk($sformatf("vec%0d_q8", i), 64'(q8), 64'(tbl[i].exp));
      chk($sformatf("vec%0d_q8r", i), 64'(q8r), 64'(m8r));
    end

    // Async reset between edges, with en=1/D=FF also present across the
    // following edge: reset must win.
    @(negedge clk);
    #2;
    rest = 1'b1; en = 1'b1; d8 = 8'hFF;
    #1;
    chk("midrst_q8",  64'(q8),  64'h00);
    chk("midrst_q8r", 64'(q8r), 64'(RV_ALT));
    step();
    chk("prio_q8",  64'(q8),  64'h00);
    chk("prio_q8r", 64'(q8r), 64'(RV_ALT));

    // Release reset with a load pending: first edge captures.
    @(negedge clk);
    rest = 1'b0; en = 1'b1; d8 = 8'h08;
    step();
    chk("release_q8",  64'(q8),  64'h08);
    chk("release_q8r", 64'(q8r), 64'h08);

    // Width sweep on the 1-bit and 32-bit registers.
    @(negedge clk);
    en = 1'b0; en_w = 1'b1;
    for (int i = 0; i < 32; i++) begin
      logic [31:0] w1;
      w1 = 32'h1 << i;
      @(negedge clk);
      d32 = w1;
      d1  = 1'(i % 2 == 0);
      step();
      chk($sformatf("walk32_%0d", i), 64'(q32), 64'(w1));
      chk($sformatf("walk1_%0d", i), 64'(q1), 64'(i % 2 == 0));
    end
    chk("walk_q8_hold", 64'(q8), 64'h08);

    // Randomised traffic against the model.
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      rest = 1'($urandom_range(0, 7) == 0);
      en   = 1'($urandom_range(0, 1));
      en_w = 1'($urandom_range(0, 1));
      d8   = 8'($urandom);
      d1   = 1'($urandom_range(0, 1));
      d32  = $urandom;
      step();
      check_all($sformatf("rnd%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
